iob_vexriscv_bus_arbiter: RTL

// Shares one IOb native memory port between the VexRiscv instruction bus (port 0) and data bus
// (port 1). Each port has a one-entry request buffer; a round-robin FSM issues one transaction at a

---
 rtl/iob_vexriscv_bus_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/iob_vexriscv_bus_arbiter.sv
// Round-robin arbiter sharing one IOb native port between the VexRiscv ibus (port 0) and dbus (port 1).
// Optional watchdog abort enabled by defining IOB_ARB_TIMEOUT_EN.
module iob_vexriscv_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    input  logic                m1_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;

    // Handshake: a request is taken on the edge where mX_valid & mX_req_ready are both high;
    // the shared port completes on the edge where s_valid & s_ready are both high.
    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic              pend0_q, pend0_d, pend1_q, pend1_d;
    logic [ADDR_W-1:0] b0_addr_q, b0_addr_d, b1_addr_q, b1_addr_d;
    logic [DATA_W-1:0] b0_wdata_q, b0_wdata_d, b1_wdata_q, b1_wdata_d;
    logic [STRB_W-1:0] b0_wstrb_q, b0_wstrb_d, b1_wstrb_q, b1_wstrb_d;
    logic              s_valid_q, s_valid_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;
    logic              m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic busy, owner, done, abort, finish, cap0, cap1;

    assign busy  = (state_q != ST_IDLE);
    assign owner = (state_q == ST_BUSY1);
    // s_ready is only meaningful once s_valid is actually presented
    assign done  = busy & s_valid_q & s_ready;
    assign cap0  = m0_valid & ~pend0_q;
    assign cap1  = m1_valid & ~pend1_q;

`ifdef IOB_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_err_q, timeout_err_d;

    // Count reaches the all-ones terminal value on this edge; a simultaneous s_ready wins.
    assign abort = busy & ~done & (cnt_q == TMO_LAST);

    always_comb begin
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q | abort;
        if (!busy) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign finish = done | abort;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        pend0_d    = pend0_q;
        pend1_d    = pend1_q;
        b0_addr_d  = b0_addr_q;
        b0_wdata_d = b0_wdata_q;
        b0_wstrb_d = b0_wstrb_q;
        b1_addr_d  = b1_addr_q;
        b1_wdata_d = b1_wdata_q;
        b1_wstrb_d = b1_wstrb_q;
        s_valid_d  = busy & ~finish;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m0_ready_d = finish & ~owner;
        m1_ready_d = finish & owner;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        if (cap0) begin
            pend0_d    = 1'b1;
            b0_addr_d  = m0_addr;
            b0_wdata_d = m0_wdata;
            b0_wstrb_d = m0_wstrb;
        end
        if (cap1) begin
            pend1_d    = 1'b1;
            b1_addr_d  = m1_addr;
            b1_wdata_d = m1_wdata;
            b1_wstrb_d = m1_wstrb;
        end

        if (state_q == ST_BUSY0) begin
            s_addr_d  = b0_addr_q;
            s_wdata_d = b0_wdata_q;
            s_wstrb_d = b0_wstrb_q;
        end else if (state_q == ST_BUSY1) begin
            s_addr_d  = b1_addr_q;
            s_wdata_d = b1_wdata_q;
            s_wstrb_d = b1_wstrb_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Both pending: serve the port that was not served last
                if (pend0_q && pend1_q) begin
                    state_d = last_q ? ST_BUSY0 : ST_BUSY1;
                end else if (pend0_q) begin
                    state_d = ST_BUSY0;
                end else if (pend1_q) begin
                    state_d = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (finish) begin
                    state_d = ST_IDLE;
                    last_d  = owner;
                    if (owner) begin
                        pend1_d    = 1'b0;
                        m1_rdata_d = done ? s_rdata : '0;
                    end else begin
                        pend0_d    = 1'b0;
                        m0_rdata_d = done ? s_rdata : '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            b0_addr_q  <= '0;
            b0_wdata_q <= '0;
            b0_wstrb_q <= '0;
            b1_addr_q  <= '0;
            b1_wdata_q <= '0;
            b1_wstrb_q <= '0;
            s_valid_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            b0_addr_q  <= b0_addr_d;
            b0_wdata_q <= b0_wdata_d;
            b0_wstrb_q <= b0_wstrb_d;
            b1_addr_q  <= b1_addr_d;
            b1_wdata_q <= b1_wdata_d;
            b1_wstrb_q <= b1_wstrb_d;
            s_valid_q  <= s_valid_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m0_ready_q <= m0_ready_d;
            m1_ready_q <= m1_ready_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_req_ready = ~pend0_q;
    assign m1_req_ready = ~pend1_q;
    assign m0_ready     = m0_ready_q;
    assign m1_ready     = m1_ready_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign s_valid      = s_valid_q;
    assign s_addr       = s_addr_q;
    assign s_wdata      = s_wdata_q;
    assign s_wstrb      = s_wstrb_q;
    assign dbg_state    = state_q;

endmodule
